// File: rtl/mips_periph_pkg.sv
// Shared definitions for memory-mapped peripherals on the data-memory bus:
// register offsets, TCON bit positions and the default window base.
package mips_periph_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets within the peripheral window
  localparam logic [4:0] OFS_TH      = 5'h00;
  localparam logic [4:0] OFS_TL      = 5'h04;
  localparam logic [4:0] OFS_TCON    = 5'h08;
  localparam logic [4:0] OFS_SYSTICK = 5'h14;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

endpackage

// File: rtl/timer_irq_peripheral_if.sv
// Data-memory bus slice seen by the timer: CPU drives strobes, address and store
// data; the peripheral returns load data and its window-select flag.
interface timer_irq_peripheral_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Sel;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, Sel
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, Sel
  );
endinterface

// File: rtl/timer_prescaler.sv
// Divides the clock into count ticks: one tick every PRESCALE cycles while enabled.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] Last = 16'(PRESCALE - 1);

  logic [15:0] pcQ;

  // Disabling the timer or rewriting TL restarts the divide phase
  always_ff @(posedge clk) begin
    if (reset || !en || clr) begin
      pcQ <= '0;
    end else if (pcQ == Last) begin
      pcQ <= '0;
    end else begin
      pcQ <= pcQ + 16'd1;
    end
  end

  assign tick = en & (pcQ == Last);

endmodule

// File: rtl/timer_irq_peripheral.sv
// Memory-mapped reload timer with level IRQ and free-running SYSTICK counter.
// Define TIMER_PRESCALE_EN to divide the count rate by PRESCALE.
module timer_irq_peripheral
  import mips_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  timer_irq_peripheral_if.slave  bus,
  output logic                   IRQ
);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : gPrescaleRange
    $error("PRESCALE must be in 1..65535");
  end

  logic [31:0] thQ, thD;
  logic [31:0] tlQ, tlD;
  logic [2:0]  tconQ, tconD;
  logic [31:0] systickQ;

  logic        hit;
  logic [4:0]  ofs;
  logic        thWr, tlWr, tconWr;
  logic        tick, count, overflow;
  logic [31:0] readMux;
  logic        unusedAddr;

  assign hit        = (bus.Addr[31:5] == BASE_ADDR[31:5]);
  assign ofs        = {bus.Addr[4:2], 2'b00};
  assign unusedAddr = ^bus.Addr[1:0];

  assign thWr   = bus.MemWrite & hit & (ofs == OFS_TH);
  assign tlWr   = bus.MemWrite & hit & (ofs == OFS_TL);
  assign tconWr = bus.MemWrite & hit & (ofs == OFS_TCON);

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) uPrescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tconQ[TCON_EN]),
    .clr   (tlWr),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign count    = tick & tconQ[TCON_EN];
  assign overflow = count & (tlQ == 32'hFFFF_FFFF);

  always_comb begin
    thD = thWr ? bus.WriteData : thQ;

    // A CPU store to TL beats both increment and reload; reload uses the pre-write TH
    tlD = tlQ;
    if (tlWr) begin
      tlD = bus.WriteData;
    end else if (overflow) begin
      tlD = thQ;
    end else if (count) begin
      tlD = tlQ + 32'd1;
    end

    // Overflow set dominates a same-cycle software clear so no event is lost
    tconD = tconQ;
    if (tconWr) begin
      tconD = bus.WriteData[2:0];
      if (overflow && bus.WriteData[TCON_IE]) begin
        tconD[TCON_ST] = 1'b1;
      end
    end else if (overflow && tconQ[TCON_IE]) begin
      tconD[TCON_ST] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thQ      <= '0;
      tlQ      <= '0;
      tconQ    <= '0;
      systickQ <= '0;
    end else begin
      thQ      <= thD;
      tlQ      <= tlD;
      tconQ    <= tconD;
      systickQ <= systickQ + 32'd1;
    end
  end

  always_comb begin
    readMux = '0;
    if (bus.MemRead && hit) begin
      case (ofs)
        OFS_TH:      readMux = thQ;
        OFS_TL:      readMux = tlQ;
        OFS_TCON:    readMux = {29'd0, tconQ};
        OFS_SYSTICK: readMux = systickQ;
        default:     readMux = '0;
      endcase
    end
  end

  assign bus.ReadData = readMux;
  assign bus.Sel      = hit;
  assign IRQ          = tconQ[TCON_IE] & tconQ[TCON_ST];

endmodule

// File: doc/timer_irq_peripheral.md
Name: timer_irq_peripheral

Overview:
- Memory-mapped timer peripheral. It is the source of the IRQ line that the CPU control unit consumes to force the exception PC path.
- Sits on the data-memory bus beside data RAM.
- The CPU programs a reload value (TH), a counter (TL) and a control/status register (TCON).
- On counter overflow the block reloads TL from TH and raises a level IRQ that stays high until software clears it.
- Also provides a free-running read-only cycle counter (SYSTICK).

Parameters:
- BASE_ADDR, 32'h4000_0000: word-aligned base of the peripheral window.
- PRESCALE, 1: clock cycles per TL increment (range 1..65535); used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  bus read strobe
- MemWrite  input  1  bus write strobe
- Addr  input  32  byte address from the ALU
- WriteData  input  32  store data
- ReadData  output  32  load data (combinational)
- Sel  output  1  high when Addr falls in BASE_ADDR..BASE_ADDR+0x1F; the top level uses it to mux ReadData against RAM
- IRQ  output  1  interrupt request to the control unit

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00: TH, RW, 32 bits.
  - 0x04: TL, RW, 32 bits.
  - 0x08: TCON, RW, bits [2:0]. Bit 0 = EN (count enable), bit 1 = IE (interrupt enable), bit 2 = ST (overflow status). Bits [31:3] read as 0.
  - 0x14: SYSTICK, RO, 32 bits.
  - All other in-window offsets read 0; writes to them are ignored.
- Reset: TH=0, TL=0, TCON=0, SYSTICK=0. IRQ=0. ReadData=0.
- Address decode: Addr[1:0] is ignored.
- Writes occur at the clk edge when MemWrite=1 and the address hits.
- Reads are combinational: ReadData = selected register when MemRead=1 and Sel=1, else 0.
- SYSTICK increments by 1 every cycle after reset and wraps 0xFFFF_FFFF -> 0. Writes to it are ignored.
- Tick: every cycle (PRESCALE path described under Optional Feature).
- Counting: on a tick with EN=1:
  - If TL==0xFFFF_FFFF: TL <= TH. If IE=1, ST <= 1. This is the overflow event.
  - Otherwise: TL <= TL+1.
  - EN=0 freezes TL; SYSTICK keeps counting.
- IRQ = IE & ST, a registered-bit-derived level.
  - Latency: IRQ is asserted in the cycle after the edge at which TL was 0xFFFF_FFFF.
  - It stays high until software writes TCON with ST=0 or IE=0.
- Simultaneous events:
  - CPU write to TL + overflow in the same cycle: the CPU value wins; no reload.
  - CPU write to TH + overflow: the reload uses the old TH; the new TH is stored.
  - CPU write to TCON + overflow with IE=1 in the written value: EN and IE take the written value; ST = written ST OR 1 (set dominates, so no event is lost).
  - If the written IE=0, ST takes the written value.
- Reset mid-count clears everything in the same edge, including a pending IRQ.
- Writes are never stalled; the block has no wait states.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - A 16-bit prescale counter PC counts 0..PRESCALE-1 while EN=1 and wraps.
  - A tick occurs only when PC==PRESCALE-1.
  - PC resets to 0 on reset, when EN=0, and on any write to TL.
- Not defined: tick=1 every cycle, PRESCALE is ignored, and no prescale register is synthesised.

Decomposition:
- Shared package mips_periph_pkg holds:
  - Offset constants: OFS_TH, OFS_TL, OFS_TCON, OFS_SYSTICK.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_ST=2.
  - The default base address.
- One sub-module is natural: timer_prescaler, which outputs tick (present only under TIMER_PRESCALE_EN).
- The register file and decode stay in the top module.

Test Plan:
1. Reset, then a read of offsets 0x00/0x04/0x08 -> all return 0. IRQ=0. SYSTICK reads 5 after 5 cycles.
2. Write TH=0xFFFF_FFF0, TL=0xFFFF_FFFD, TCON=3 -> TL reads ...FE, ...FF, then 0xFFFF_FFF0. IRQ rises the cycle after TL=...FF. TCON reads 7.
3. With IRQ high, write TCON=3 -> IRQ drops the next cycle. TL continues to 0xFFFF_FFF1.
4. Write TCON=3 in the exact cycle TL=0xFFFF_FFFF -> TCON reads 7 and IRQ=1 (set dominates). The same-cycle TL write of 0x10 -> TL=0x10 with no reload.
5. TCON=1 (IE=0) through an overflow -> TL reloads, ST stays 0, IRQ stays 0. Assert reset mid-count -> TL=0 next cycle.
6. With TIMER_PRESCALE_EN and PRESCALE=4, TL=0, TCON=1 -> TL increments once every 4 cycles: reads 0,0,0,1 after 4 cycles, 2 after 8. Any read outside the window -> Sel=0, ReadData=0.
